// File: rtl/slink_gpio_pkg.sv
// Shared S-Link GPIO definitions: aligner FSM states, default training word and the
// search-timeout limit.
package slink_gpio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      CHECK  = 2'd2,
      LOCKED = 2'd3
   } rx_state_e;

   localparam logic [7:0] SYNC_PATTERN_DEFAULT = 8'hBC;
   localparam logic [7:0] ALIGN_TIMEOUT_LIMIT  = 8'd255;

endpackage : slink_gpio_pkg

// File: rtl/slink_gpio_rx_align_if.sv
// Lane-side inputs and aligned-word outputs of the S-Link GPIO RX aligner.
// slave = aligner side, master = the logic that feeds the lane and consumes words.
interface slink_gpio_rx_align_if #(
   parameter int PAR_DATA_WIDTH = 8,
   parameter int IO_DATA_WIDTH  = 1
);
   localparam int OFFSET_W = $clog2(PAR_DATA_WIDTH / IO_DATA_WIDTH);

   logic                      rx_en;
   logic                      align_req;
   logic [IO_DATA_WIDTH-1:0]  rx_ser_data;
   logic [PAR_DATA_WIDTH-1:0] rx_par_data;
   logic                      rx_par_valid;
   logic                      rx_locked;
   logic [OFFSET_W-1:0]       rx_slip_offset;
   logic                      align_err;

   modport slave (
      input  rx_en,
      input  align_req,
      input  rx_ser_data,
      output rx_par_data,
      output rx_par_valid,
      output rx_locked,
      output rx_slip_offset,
      output align_err
   );

   modport master (
      output rx_en,
      output align_req,
      output rx_ser_data,
      input  rx_par_data,
      input  rx_par_valid,
      input  rx_locked,
      input  rx_slip_offset,
      input  align_err
   );

endinterface : slink_gpio_rx_align_if

// File: rtl/slink_demet_reset.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on the
// asynchronous reset.
module slink_demet_reset (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   output logic o_sig
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_sig;
         r_sync <= r_meta;
      end
   end

   assign o_sig = r_sync;

endmodule : slink_demet_reset

// File: rtl/slink_gpio_rx_align.sv
// S-Link GPIO RX word aligner: slips the boundary one chunk at a time until SYNC_PATTERN repeats
// LOCK_COUNT times, then streams aligned words. Optional macro: SLINK_GPIO_RX_ALIGN_TIMEOUT_EN.
module slink_gpio_rx_align
   import slink_gpio_pkg::*;
#(
   parameter int                        PAR_DATA_WIDTH = 8,
   parameter int                        IO_DATA_WIDTH  = 1,
   parameter logic [PAR_DATA_WIDTH-1:0] SYNC_PATTERN   = PAR_DATA_WIDTH'(SYNC_PATTERN_DEFAULT),
   parameter int                        LOCK_COUNT     = 4
) (
   input  logic                 serial_clk_gated,
   input  logic                 serial_reset,
   slink_gpio_rx_align_if.slave bus
);

   localparam int               DIV_RATIO = PAR_DATA_WIDTH / IO_DATA_WIDTH;
   localparam int               CNT_W     = $clog2(DIV_RATIO);
   localparam int               SR_W      = PAR_DATA_WIDTH - IO_DATA_WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_RATIO - 1);
   localparam logic [3:0]       LOCK_CNT  = 4'(LOCK_COUNT);

   logic [1:0]                w_sync_in;
   logic [1:0]                w_sync_out;
   logic                      w_rx_en_s;
   logic                      w_align_req_s;
   logic                      w_req_rise;
   logic                      w_boundary;
   logic                      w_cand_hit;
   logic                      w_lock_now;
   logic [PAR_DATA_WIDTH-1:0] w_sr_next;
   logic [3:0]                w_match_inc;

   rx_state_e                 r_state;
   logic [IO_DATA_WIDTH-1:0]  r_samp;
   logic [SR_W-1:0]           r_sr;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_slip_hold;
   logic [CNT_W-1:0]          r_slip;
   logic [3:0]                r_match;
   logic                      r_req_d;
   logic [PAR_DATA_WIDTH-1:0] r_par_data;
   logic                      r_par_valid;
   logic                      r_locked;

   assign w_sync_in = {bus.align_req, bus.rx_en};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_demet
         slink_demet_reset u_demet (
            .clk   (serial_clk_gated),
            .reset (serial_reset),
            .i_sig (w_sync_in[gi]),
            .o_sig (w_sync_out[gi])
         );
      end
   endgenerate

   assign w_rx_en_s     = w_sync_out[0];
   assign w_align_req_s = w_sync_out[1];
   assign w_req_rise    = w_align_req_s & ~r_req_d;

   // Lane sampled mid-bit on the falling edge; half a cycle later it is shifted in.
   always_ff @(negedge serial_clk_gated or posedge serial_reset) begin
      if (serial_reset) begin
         r_samp <= '0;
      end else begin
         r_samp <= w_rx_en_s ? bus.rx_ser_data : '0;
      end
   end

   // Only the upper chunks are stored; the oldest chunk leaves through w_sr_next.
   assign w_sr_next   = {r_samp, r_sr};
   assign w_boundary  = (r_cnt == CNT_LAST);
   assign w_cand_hit  = (w_sr_next == SYNC_PATTERN);
   assign w_match_inc = r_match + 4'd1;
   assign w_lock_now  = w_boundary && w_cand_hit && !w_req_rise &&
                        (((r_state == SEARCH) && (LOCK_CNT == 4'd1)) ||
                         ((r_state == CHECK) && (w_match_inc == LOCK_CNT)));

   always_ff @(posedge serial_clk_gated or posedge serial_reset) begin
      if (serial_reset) begin
         r_state     <= IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_slip_hold <= 1'b0;
         r_slip      <= '0;
         r_match     <= 4'd0;
         r_req_d     <= 1'b0;
         r_par_data  <= '0;
         r_par_valid <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_req_d     <= w_align_req_s;
         r_par_valid <= 1'b0;

         if (!w_rx_en_s || (r_state == IDLE)) begin
            r_state     <= w_rx_en_s ? SEARCH : IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_slip_hold <= 1'b0;
            r_slip      <= '0;
            r_match     <= 4'd0;
            r_par_data  <= '0;
            r_locked    <= 1'b0;
         end else begin
            r_sr <= w_sr_next[PAR_DATA_WIDTH-1:IO_DATA_WIDTH];

            // A slip parks the counter at 0 for one extra cycle, widening the window by a chunk.
            if (r_slip_hold) begin
               r_slip_hold <= 1'b0;
            end else begin
               r_cnt <= w_boundary ? '0 : r_cnt + CNT_W'(1);
            end

            if (w_req_rise) begin
               r_state  <= SEARCH;
               r_locked <= 1'b0;
               r_match  <= 4'd0;
            end else if (w_lock_now) begin
               r_state     <= LOCKED;
               r_locked    <= 1'b1;
               r_match     <= w_match_inc;
               r_par_data  <= w_sr_next;
               r_par_valid <= 1'b1;
            end else if (w_boundary) begin
               case (r_state)
                  SEARCH: begin
                     if (w_cand_hit) begin
                        r_state <= CHECK;
                        r_match <= 4'd1;
                     end else begin
                        r_slip_hold <= 1'b1;
                        r_slip      <= r_slip + CNT_W'(1);
                     end
                  end
                  CHECK: begin
                     if (w_cand_hit) begin
                        r_match <= w_match_inc;
                     end else begin
                        r_state <= SEARCH;
                        r_match <= 4'd0;
                     end
                  end
                  LOCKED: begin
                     r_par_data  <= w_sr_next;
                     r_par_valid <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

`ifdef SLINK_GPIO_RX_ALIGN_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic       r_align_err;

   // Counts unlocked boundaries; the error flag is sticky until the aligner drops to IDLE.
   always_ff @(posedge serial_clk_gated or posedge serial_reset) begin
      if (serial_reset) begin
         r_tmo_cnt   <= 8'd0;
         r_align_err <= 1'b0;
      end else if (!w_rx_en_s || (r_state == IDLE)) begin
         r_tmo_cnt   <= 8'd0;
         r_align_err <= 1'b0;
      end else if (w_lock_now || (r_state == LOCKED)) begin
         r_tmo_cnt <= 8'd0;
      end else if (w_boundary && !w_req_rise && (r_tmo_cnt != ALIGN_TIMEOUT_LIMIT)) begin
         r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (r_tmo_cnt == (ALIGN_TIMEOUT_LIMIT - 8'd1)) begin
            r_align_err <= 1'b1;
         end
      end
   end

   assign bus.align_err = r_align_err;
`else
   assign bus.align_err = 1'b0;
`endif

   assign bus.rx_par_data    = r_par_data;
   assign bus.rx_par_valid   = r_par_valid;
   assign bus.rx_locked      = r_locked;
   assign bus.rx_slip_offset = r_slip;

endmodule : slink_gpio_rx_align

// File: tb/tb_slink_gpio_rx_align.sv
// Directed bench for slink_gpio_rx_align (PAR=8, IO=1, sync 8'hBC, lock after 4 matches).
// Stimulus pushes expected words into a queue; a monitor pops them on every rx_par_valid.
module tb_slink_gpio_rx_align;

`ifdef SLINK_GPIO_RX_ALIGN_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic       prev_valid = 1'b0;

   always #5 clk = ~clk;

   slink_gpio_rx_align_if #(.PAR_DATA_WIDTH(8), .IO_DATA_WIDTH(1)) bus ();

   slink_gpio_rx_align #(
      .PAR_DATA_WIDTH (8),
      .IO_DATA_WIDTH  (1),
      .SYNC_PATTERN   (8'hBC),
      .LOCK_COUNT     (4)
   ) dut (
      .serial_clk_gated (clk),
      .serial_reset     (rst),
      .bus              (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // One lane bit per cycle, driven just after the rising edge, LSB first.
   task automatic send_word(input logic [7:0] w, input bit expect_out);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         bus.rx_ser_data = w[i];
      end
      if (expect_out) exp_q.push_back(w);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.rx_ser_data = 1'b0;
      end
   endtask

   // Two idle bits line the first word up with the first search window; extra bits shift it.
   task automatic enable(input int extra_bits);
      @(posedge clk); #1;
      bus.rx_en = 1'b1;
      idle_bits(2 + extra_bits);
   endtask

   task automatic drop_en(input logic was_locked);
      bus.rx_en = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("locked_during_en_sync", bus.rx_locked, was_locked);
      @(posedge clk); #1;
      check("idle_locked", bus.rx_locked, 0);
      check("idle_par_data", bus.rx_par_data, 0);
      check("idle_par_valid", bus.rx_par_valid, 0);
      check("idle_slip_offset", bus.rx_slip_offset, 0);
      check("idle_align_err", bus.align_err, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(posedge clk); #1;
         if (bus.rx_par_valid) begin
            check("valid_single_cycle", {31'd0, prev_valid}, 0);
            check("locked_with_valid", bus.rx_locked, 1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.rx_par_data);
            end else begin
               e = exp_q.pop_front();
               check("word_data", bus.rx_par_data, e);
               $display("word 0x%0h expected 0x%0h", bus.rx_par_data, e);
            end
         end
         prev_valid = bus.rx_par_valid;
      end
   end

   initial begin : stimulus
      rst             = 1'b1;
      bus.rx_en       = 1'b0;
      bus.align_req   = 1'b0;
      bus.rx_ser_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_par_data", bus.rx_par_data, 0);
      check("reset_par_valid", bus.rx_par_valid, 0);
      check("reset_locked", bus.rx_locked, 0);
      check("reset_slip_offset", bus.rx_slip_offset, 0);
      check("reset_align_err", bus.align_err, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Aligned stream: lock on the 4th sync word, which is also the first delivered word.
      enable(0);
      for (int k = 0; k < 5; k++) begin
         send_word(8'hBC, k >= 3);
         if (k == 3) check("a_unlocked_before_4th", bus.rx_locked, 0);
      end
      send_word(8'h5A, 1'b1);
      check("a_locked", bus.rx_locked, 1);
      check("a_slip_offset", bus.rx_slip_offset, 0);
      send_word(8'hC3, 1'b1);
      drop_en(1'b1);

      // Stream delayed by 3 bits: three slips, then lock and payload.
      enable(3);
      for (int k = 0; k < 7; k++) send_word(8'hBC, k == 6);
      send_word(8'h5A, 1'b1);
      check("b_locked", bus.rx_locked, 1);
      check("b_slip_offset", bus.rx_slip_offset, 3);
      send_word(8'hC3, 1'b1);

      // Re-alignment request with unchanged phase keeps the offset.
      bus.align_req = 1'b1;
      send_word(8'hBC, 1'b0);
      bus.align_req = 1'b0;
      check("b_realign_unlocked", bus.rx_locked, 0);
      check("b_realign_offset_kept", bus.rx_slip_offset, 3);
      send_word(8'hBC, 1'b0);
      send_word(8'hBC, 1'b0);
      send_word(8'hBC, 1'b1);
      send_word(8'h5A, 1'b1);
      check("b_relocked", bus.rx_locked, 1);
      check("b_relock_offset", bus.rx_slip_offset, 3);
      drop_en(1'b1);

      // Corrupted word during CHECK restarts the match count without slipping.
      enable(0);
      send_word(8'hBC, 1'b0);
      send_word(8'hBC, 1'b0);
      send_word(8'hBD, 1'b0);
      send_word(8'hBC, 1'b0);
      send_word(8'hBC, 1'b0);
      send_word(8'hBC, 1'b0);
      check("c_unlocked_after_corrupt", bus.rx_locked, 0);
      send_word(8'hBC, 1'b1);
      send_word(8'h5A, 1'b1);
      check("c_locked", bus.rx_locked, 1);
      check("c_slip_offset", bus.rx_slip_offset, 0);
      drop_en(1'b1);

      // Constant zeros: never locks; timeout flag only when the feature is built in.
      enable(0);
      idle_bits(900);
      check("d_align_err_early", bus.align_err, 0);
      idle_bits(1800);
      check("d_align_err_set", bus.align_err, TMO_EN);
      check("d_never_locked", bus.rx_locked, 0);
      idle_bits(200);
      check("d_align_err_sticky", bus.align_err, TMO_EN);
      drop_en(1'b0);

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_slink_gpio_rx_align
